// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundle of the write-arbiter's requester, register-file and decode signals.
//
//   hold        freeze arbitration
//   req_valid   per-requester write request            [NREQ]
//   req_addr    packed destination addresses           [NREQ*AW]
//   req_data    packed write data                      [NREQ*DW]
//   req_ready   one-hot grant, combinational           [NREQ]
//   wr_en       register-file write strobe (registered)
//   wr_addr     register-file write address (registered)
//   wr_data     register-file write data (registered)
//   rd_addr1/2  decode source addresses
//   hazard1/2   source has a pending or in-flight write
//   fwd_valid1/2, fwd_data1/2  forwarding of the in-flight write
//
// Modports: slave = arbiter side, master = requester/decode/register-file side.
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [AW-1:0]        rd_addr1;
    logic [AW-1:0]        rd_addr2;
    logic                 hazard1;
    logic                 hazard2;
    logic                 fwd_valid1;
    logic                 fwd_valid2;
    logic [DW-1:0]        fwd_data1;
    logic [DW-1:0]        fwd_data2;

    modport slave (
        input  hold, req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        output req_ready, wr_en, wr_addr, wr_data,
               hazard1, hazard2, fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
    );

    modport master (
        output hold, req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        input  req_ready, wr_en, wr_addr, wr_data,
               hazard1, hazard2, fwd_valid1, fwd_valid2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Round-robin arbiter sharing the register file's single write port between
// NREQ writeback requesters, plus a read-hazard scoreboard for decode.
//
// Ports:
//   clk   clock, all state updates on posedge
//   rst   asynchronous, active-high reset
//   bus   regfile_write_arbiter_if.slave (requests, grant, write port, decode)
//
// Optional build macro: REGARB_FORWARD_EN
//   defined   -> an in-flight write matching a source is forwarded
//                (fwd_valid/fwd_data) and no longer raises that hazard
//   undefined -> forwarding outputs tied 0, in-flight writes raise hazards
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_rr_ptr;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;

    logic [AW-1:0]   w_addr [NREQ];
    logic [DW-1:0]   w_data [NREQ];
    logic            w_found;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_cand;
    logic [NREQ-1:0] w_grant;
    logic            w_pend1;
    logic            w_pend2;
    logic            w_nz1;
    logic            w_nz2;
    logic            w_fly1;
    logic            w_fly2;

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g] = bus.req_addr[g*AW +: AW];
        assign w_data[g] = bus.req_data[g*DW +: DW];
    end

    // Search starts one past the last winner and wraps, so the last winner
    // is always considered last.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_grant = '0;
        if (!rst && !bus.hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                w_cand = PW'((int'(r_rr_ptr) + k) % NREQ);
                if (!w_found && bus.req_valid[w_cand]) begin
                    w_found = 1'b1;
                    w_gidx  = w_cand;
                end
            end
            if (w_found) begin
                w_grant[w_gidx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = w_grant;

    // A grant to address 0 still loads addr/data and moves the pointer,
    // but never strobes the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rr_ptr  <= PW'(NREQ - 1);
        end else if (w_found) begin
            r_wr_addr <= w_addr[w_gidx];
            r_wr_data <= w_data[w_gidx];
            r_rr_ptr  <= w_gidx;
            r_wr_en   <= (w_addr[w_gidx] != '0);
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;

    // Pending matches include the request being granted this cycle.
    always_comb begin
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && (w_addr[i] == bus.rd_addr1)) w_pend1 = 1'b1;
            if (bus.req_valid[i] && (w_addr[i] == bus.rd_addr2)) w_pend2 = 1'b1;
        end
    end

    assign w_nz1  = (bus.rd_addr1 != '0);
    assign w_nz2  = (bus.rd_addr2 != '0);
    assign w_fly1 = r_wr_en && (r_wr_addr == bus.rd_addr1);
    assign w_fly2 = r_wr_en && (r_wr_addr == bus.rd_addr2);

`ifdef REGARB_FORWARD_EN
    assign bus.hazard1    = !rst && w_nz1 && w_pend1;
    assign bus.hazard2    = !rst && w_nz2 && w_pend2;
    assign bus.fwd_valid1 = w_nz1 && w_fly1;
    assign bus.fwd_valid2 = w_nz2 && w_fly2;
    assign bus.fwd_data1  = (w_nz1 && w_fly1) ? r_wr_data : '0;
    assign bus.fwd_data2  = (w_nz2 && w_fly2) ? r_wr_data : '0;
`else
    assign bus.hazard1    = !rst && w_nz1 && (w_pend1 || w_fly1);
    assign bus.hazard2    = !rst && w_nz2 && (w_pend2 || w_fly2);
    assign bus.fwd_valid1 = 1'b0;
    assign bus.fwd_valid2 = 1'b0;
    assign bus.fwd_data1  = '0;
    assign bus.fwd_data2  = '0;
`endif
endmodule
